// File: rtl/utils_top.sv
// -----------------------------------------------------------------------------
// utils_top
// Shared definitions for the fetch-stage branch predictor:
//   - bht_cnt_t   : 2-bit saturating counter state (SNT/WNT/WT/ST)
//   - CNT_RST     : counter value after reset (weakly not-taken)
//   - IDX_W_DEF   : default log2 of BHT/BTB entry count
//   - TAG_W_DEF   : default BTB tag width
//   - cnt_step()  : next value of a counter trained up or down
//   - sat_inc32() : 32-bit increment that sticks at all-ones
// -----------------------------------------------------------------------------
package utils_top;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_cnt_t;

   localparam bht_cnt_t CNT_RST   = WNT;
   localparam int       IDX_W_DEF = 6;
   localparam int       TAG_W_DEF = 8;

   // One training step; the end states absorb further steps in their direction.
   function automatic bht_cnt_t cnt_step(input bht_cnt_t cur, input logic up);
      bht_cnt_t nxt;
      nxt = cur;
      case (cur)
         SNT:     nxt = up ? WNT : SNT;
         WNT:     nxt = up ? WT  : SNT;
         WT:      nxt = up ? ST  : WNT;
         ST:      nxt = up ? ST  : WT;
         default: nxt = CNT_RST;
      endcase
      return nxt;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] val);
      return (&val) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/branch_sat_cnt2.sv
// -----------------------------------------------------------------------------
// branch_sat_cnt2
// One BHT entry: a 2-bit saturating up/down counter.
// Ports:
//   clk   in  core clock
//   rst_n in  synchronous active-low reset, loads WNT
//   en    in  train this entry this cycle
//   up    in  1 = branch taken (count up), 0 = not taken (count down)
//   cnt   out current counter state
// -----------------------------------------------------------------------------
module branch_sat_cnt2
   import utils_top::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     en,
   input  logic     up,
   output bht_cnt_t cnt
);

   bht_cnt_t cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg <= CNT_RST;
      end else if (en) begin
         cnt_reg <= cnt_step(cnt_reg, up);
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/fetch_branch_predictor.sv
// -----------------------------------------------------------------------------
// fetch_branch_predictor
// Fetch-stage dynamic branch predictor: a BHT of 2-bit saturating counters
// plus a direct-mapped BTB (valid, tag, target), both indexed by PC[IDX_W+1:2].
// A lookup presented in cycle N is answered by registered outputs in cycle N+1.
// Execute-stage resolutions train the tables; an execute flush squashes the
// pending response.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   pred_vld, pred_pc           fetch lookup request and its PC
//   pred_hold                   fetch stall: response registers keep value
//   pred_out_vld                registered response valid
//   pred_taken, pred_target     prediction; target is 0 when not taken
//   upd_vld, upd_pc,
//   upd_taken, upd_target       resolved conditional branch training data
//   flush                       execute flush/redirect
//   stat_br_cnt, stat_mis_cnt   saturating resolved-branch / flush counts
// -----------------------------------------------------------------------------
module fetch_branch_predictor
   import utils_top::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pred_vld,
   input  logic [31:0] pred_pc,
   input  logic        pred_hold,
   output logic        pred_out_vld,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_vld,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        flush,
   output logic [31:0] stat_br_cnt,
   output logic [31:0] stat_mis_cnt
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_LO  = IDX_W + 2;
   localparam int TAG_HI  = IDX_W + TAG_W + 1;

   // ---------------------------------------------------------------------------
   // PC field extraction
   // ---------------------------------------------------------------------------
   logic [IDX_W-1:0] pred_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] pred_tag;
   logic [TAG_W-1:0] upd_tag;

   assign pred_idx = pred_pc[IDX_W+1:2];
   assign upd_idx  = upd_pc[IDX_W+1:2];
   assign pred_tag = pred_pc[TAG_HI:TAG_LO];
   assign upd_tag  = upd_pc[TAG_HI:TAG_LO];

   // ---------------------------------------------------------------------------
   // BHT: one saturating counter per entry
   // ---------------------------------------------------------------------------
   bht_cnt_t cnt_arr [ENTRIES];

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_bht
         logic cnt_en;
         assign cnt_en = upd_vld && (upd_idx == IDX_W'(gi));

         branch_sat_cnt2 u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (cnt_en),
            .up    (upd_taken),
            .cnt   (cnt_arr[gi])
         );
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // BTB: valid bits need a reset; tag/target storage does not, because an
   // entry is never consulted while its valid bit is clear.
   // ---------------------------------------------------------------------------
   logic [ENTRIES-1:0] btb_vld_reg;
   logic [TAG_W-1:0]   btb_tag_reg [ENTRIES];
   logic [31:0]        btb_tgt_reg [ENTRIES];

   logic btb_wr;
   assign btb_wr = upd_vld && upd_taken;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btb_vld_reg <= '0;
      end else if (btb_wr) begin
         btb_vld_reg[upd_idx] <= 1'b1;
      end
   end

   // A reset cycle also drops the same-cycle update, including its data write.
   always_ff @(posedge clk) begin
      if (rst_n && btb_wr) begin
         btb_tag_reg[upd_idx] <= upd_tag;
         btb_tgt_reg[upd_idx] <= upd_target;
      end
   end

   // ---------------------------------------------------------------------------
   // Lookup. Tables are read before this edge's update lands, so a same-cycle
   // lookup and update to one index sees the old contents.
   // ---------------------------------------------------------------------------
   logic [1:0]  look_cnt;
   logic        look_hit;
   logic [31:0] look_tgt;

   assign look_cnt = cnt_arr[pred_idx];
   assign look_tgt = btb_tgt_reg[pred_idx];
   // A counter that says taken but misses the BTB has no target: not taken.
   assign look_hit = look_cnt[1]
                     & btb_vld_reg[pred_idx]
                     & (btb_tag_reg[pred_idx] == pred_tag);

   // ---------------------------------------------------------------------------
   // Response registers. Priority: reset, flush, hold, then new lookup/idle.
   // ---------------------------------------------------------------------------
   logic        out_vld_reg;
   logic        out_taken_reg;
   logic [31:0] out_target_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_vld_reg    <= 1'b0;
         out_taken_reg  <= 1'b0;
         out_target_reg <= '0;
      end else if (flush) begin
         out_vld_reg    <= 1'b0;
         out_taken_reg  <= 1'b0;
         out_target_reg <= '0;
      end else if (!pred_hold) begin
         out_vld_reg    <= pred_vld;
         out_taken_reg  <= pred_vld & look_hit;
         out_target_reg <= (pred_vld && look_hit) ? look_tgt : '0;
      end
   end

   assign pred_out_vld = out_vld_reg;
   assign pred_taken   = out_taken_reg;
   assign pred_target  = out_target_reg;

   // ---------------------------------------------------------------------------
   // Statistics, saturating at all-ones
   // ---------------------------------------------------------------------------
   logic [31:0] stat_br_cnt_reg;
   logic [31:0] stat_mis_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_br_cnt_reg  <= '0;
         stat_mis_cnt_reg <= '0;
      end else begin
         if (upd_vld) begin
            stat_br_cnt_reg <= sat_inc32(stat_br_cnt_reg);
         end
         if (flush) begin
            stat_mis_cnt_reg <= sat_inc32(stat_mis_cnt_reg);
         end
      end
   end

   assign stat_br_cnt  = stat_br_cnt_reg;
   assign stat_mis_cnt = stat_mis_cnt_reg;

   // PC bits outside the index/tag fields and the counter LSB do not affect
   // the prediction.
   logic unused_bits;
   assign unused_bits = ^{pred_pc[31:TAG_HI+1], pred_pc[1:0],
                          upd_pc[31:TAG_HI+1], upd_pc[1:0], look_cnt[0]};

endmodule

// File: tb/tb_fetch_branch_predictor.sv
module tb_fetch_branch_predictor;

   localparam int  IDX_W   = 6;
   localparam int  TAG_W   = 8;
   localparam int  ENTRIES = 1 << IDX_W;
   localparam longint SAT  = 64'h0000_0000_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pred_vld;
   logic [31:0] pred_pc;
   logic        pred_hold;
   logic        pred_out_vld;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_vld;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        flush;
   logic [31:0] stat_br_cnt;
   logic [31:0] stat_mis_cnt;

   always #5 clk = ~clk;

   fetch_branch_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pred_vld     (pred_vld),
      .pred_pc      (pred_pc),
      .pred_hold    (pred_hold),
      .pred_out_vld (pred_out_vld),
      .pred_taken   (pred_taken),
      .pred_target  (pred_target),
      .upd_vld      (upd_vld),
      .upd_pc       (upd_pc),
      .upd_taken    (upd_taken),
      .upd_target   (upd_target),
      .flush        (flush),
      .stat_br_cnt  (stat_br_cnt),
      .stat_mis_cnt (stat_mis_cnt)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   bit chk_br = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: counters are integers 0..3 (>=2 means taken), BTB is
   // plain arrays, stats are wide integers clipped to 32 bits.
   // ---------------------------------------------------------------------------
   int          m_cnt [ENTRIES];
   bit          m_bv  [ENTRIES];
   int          m_tag [ENTRIES];
   logic [31:0] m_tgt [ENTRIES];
   bit          e_vld;
   bit          e_taken;
   logic [31:0] e_tgt;
   longint      e_br;
   longint      e_mis;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
   endfunction

   function automatic bit hit_of(input logic [31:0] pc);
      int i;
      i = idx_of(pc);
      return (m_cnt[i] >= 2) && m_bv[i] && (m_tag[i] == tag_of(pc));
   endfunction

   function automatic int cnt_next(input int c, input bit up);
      if (up) return (c >= 3) ? 3 : c + 1;
      return (c <= 0) ? 0 : c - 1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            m_cnt[i] <= 1;
            m_bv[i]  <= 1'b0;
         end
         e_vld   <= 1'b0;
         e_taken <= 1'b0;
         e_tgt   <= '0;
         e_br    <= 0;
         e_mis   <= 0;
      end else begin
         if (flush) begin
            e_vld   <= 1'b0;
            e_taken <= 1'b0;
            e_tgt   <= '0;
         end else if (!pred_hold) begin
            e_vld   <= pred_vld;
            e_taken <= pred_vld && hit_of(pred_pc);
            e_tgt   <= (pred_vld && hit_of(pred_pc)) ? m_tgt[idx_of(pred_pc)] : 32'h0;
         end
         if (upd_vld) begin
            m_cnt[idx_of(upd_pc)] <= cnt_next(m_cnt[idx_of(upd_pc)], upd_taken);
            if (upd_taken) begin
               m_bv[idx_of(upd_pc)]  <= 1'b1;
               m_tag[idx_of(upd_pc)] <= tag_of(upd_pc);
               m_tgt[idx_of(upd_pc)] <= upd_target;
            end
            e_br <= (e_br < SAT) ? e_br + 1 : SAT;
         end
         if (flush) begin
            e_mis <= (e_mis < SAT) ? e_mis + 1 : SAT;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_out_vld", {31'b0, pred_out_vld}, {31'b0, e_vld});
         chk("m_taken", {31'b0, pred_taken}, {31'b0, e_taken});
         chk("m_target", pred_target, e_tgt);
         if (chk_br) chk("m_stat_br", stat_br_cnt, e_br[31:0]);
         chk("m_stat_mis", stat_mis_cnt, e_mis[31:0]);
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus with hand-computed expectations
   // ---------------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pred_vld  = 1'b0;
      pred_hold = 1'b0;
      upd_vld   = 1'b0;
      upd_taken = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      idle();
      pred_vld = 1'b1;
      pred_pc  = pc;
   endtask

   task automatic train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input int n);
      for (int k = 0; k < n; k++) begin
         idle();
         upd_vld    = 1'b1;
         upd_pc     = pc;
         upd_taken  = tk;
         upd_target = tgt;
         cyc();
      end
   endtask

   task automatic expect_resp(input string name, input bit v, input bit t, input logic [31:0] tgt);
      chk({name, "_vld"}, {31'b0, pred_out_vld}, {31'b0, v});
      chk({name, "_taken"}, {31'b0, pred_taken}, {31'b0, t});
      chk({name, "_target"}, pred_target, tgt);
      $display("txn %s: vld=%0b taken=%0b target=%h", name, pred_out_vld, pred_taken, pred_target);
   endtask

   initial begin
      rst_n      = 1'b0;
      pred_pc    = '0;
      upd_pc     = '0;
      upd_target = '0;
      idle();
      cyc();
      cyc();
      expect_resp("reset", 1'b0, 1'b0, 32'h0);
      chk("reset_stat_br", stat_br_cnt, 32'h0);
      chk("reset_stat_mis", stat_mis_cnt, 32'h0);
      chk_en = 1'b1;
      rst_n  = 1'b1;

      // 1: cold lookup
      lookup(32'h100);
      cyc();
      expect_resp("cold", 1'b1, 1'b0, 32'h0);

      // 2: WNT -> WT -> ST, then taken x3 (stays ST), then not-taken -> WT
      train(32'h100, 1'b1, 32'h200, 2);
      lookup(32'h100);
      cyc();
      expect_resp("trained", 1'b1, 1'b1, 32'h200);
      train(32'h100, 1'b1, 32'h200, 3);
      train(32'h100, 1'b0, 32'h0, 1);
      lookup(32'h100);
      cyc();
      expect_resp("at_wt", 1'b1, 1'b1, 32'h200);

      // 3: 0x200 shares idx 0 with tag 2 vs 1
      lookup(32'h200);
      cyc();
      expect_resp("alias", 1'b1, 1'b0, 32'h0);

      // 4: same-cycle lookup + not-taken update: old WT answers, then WNT
      lookup(32'h100);
      upd_vld   = 1'b1;
      upd_pc    = 32'h100;
      upd_taken = 1'b0;
      cyc();
      expect_resp("read_old", 1'b1, 1'b1, 32'h200);
      lookup(32'h100);
      cyc();
      expect_resp("after_upd", 1'b1, 1'b0, 32'h0);
      chk("br_count7", stat_br_cnt, 32'd7);

      // hold keeps the response even with a new request or no request
      lookup(32'h200);
      pred_hold = 1'b1;
      cyc();
      expect_resp("hold1", 1'b1, 1'b0, 32'h0);
      pred_vld = 1'b0;
      cyc();
      expect_resp("hold2", 1'b1, 1'b0, 32'h0);

      // 5: flush beats hold and pred_vld
      lookup(32'h100);
      cyc();
      pred_hold = 1'b1;
      flush     = 1'b1;
      cyc();
      expect_resp("flush", 1'b0, 1'b0, 32'h0);
      chk("mis_count1", stat_mis_cnt, 32'd1);

      // 6: retrain, then reset with a same-cycle update and lookup
      train(32'h100, 1'b1, 32'h300, 2);
      lookup(32'h100);
      cyc();
      expect_resp("retrained", 1'b1, 1'b1, 32'h300);
      lookup(32'h100);
      upd_vld    = 1'b1;
      upd_pc     = 32'h100;
      upd_taken  = 1'b1;
      upd_target = 32'h300;
      rst_n      = 1'b0;
      cyc();
      expect_resp("mid_reset", 1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;
      lookup(32'h100);
      cyc();
      expect_resp("post_reset", 1'b1, 1'b0, 32'h0);
      chk("post_reset_br", stat_br_cnt, 32'h0);
      chk("post_reset_mis", stat_mis_cnt, 32'h0);

      // saturation of stat_br_cnt
      chk_br = 1'b0;
      idle();
      upd_vld = 1'b1;
      upd_pc  = 32'h400;
      force dut.stat_br_cnt_reg = 32'hFFFF_FFFF;
      cyc();
      release dut.stat_br_cnt_reg;
      cyc();
      chk("sat_br_1", stat_br_cnt, 32'hFFFF_FFFF);
      $display("txn sat1: stat_br_cnt=%h", stat_br_cnt);
      cyc();
      chk("sat_br_2", stat_br_cnt, 32'hFFFF_FFFF);
      $display("txn sat2: stat_br_cnt=%h", stat_br_cnt);

      idle();
      cyc();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_branch_predictor.md
Name: fetch_branch_predictor

Overview:
- Fetch-stage dynamic branch predictor. It supplies the br_pred/target that the execute stage later checks against the resolved branch outcome.
- Contents: a BHT of 2-bit saturating counters and a direct-mapped BTB (tag plus target), both indexed by PC.
- Lookup latency is one cycle, registered.
- The table is trained by execute-stage resolution updates. The pending prediction is squashed on an execute flush.

Parameters:
- IDX_W, 6, log2 of BHT/BTB entry count (64 entries).
- TAG_W, 8, BTB tag width taken from PC bits above the index.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- pred_vld  in  1  fetch lookup request this cycle
- pred_pc  in  32  PC of fetched instruction
- pred_hold  in  1  fetch stall; response registers hold their value
- pred_out_vld  out  1  registered response valid
- pred_taken  out  1  predicted taken (becomes br_pred downstream)
- pred_target  out  32  predicted target; 0 when pred_taken=0
- upd_vld  in  1  execute resolved a conditional branch
- upd_pc  in  32  PC of resolved branch
- upd_taken  in  1  actual branch outcome
- upd_target  in  32  actual taken target
- flush  in  1  execute flush/redirect
- stat_br_cnt  out  32  resolved-branch count, saturating
- stat_mis_cnt  out  32  mispredict count (flush cycles), saturating

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - All counters go to 2'b01 (weakly not-taken).
  - All BTB valid bits clear.
  - pred_out_vld=0, pred_taken=0, pred_target=0, both stat counters=0.
  - A reset asserted mid-operation discards the in-flight response and any same-cycle update.
- Indexing:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - PC bits [1:0] are ignored.
- Lookup, cycle N with pred_vld=1 and pred_hold=0: at cycle N+1 the outputs are
  - pred_out_vld=1;
  - pred_taken = cnt[idx][1] & btb_vld[idx] & (btb_tag[idx]==tag);
  - pred_target = btb_tgt[idx] if pred_taken, else 0.
- A counter-taken lookup that misses the BTB predicts not-taken.
- pred_vld=0 and pred_hold=0: pred_out_vld=0 next cycle, and the taken/target outputs are zeroed.
- pred_hold=1: all pred_* outputs hold their value. The lookup is not performed, whatever pred_vld is.
- flush=1: pred_out_vld=0, pred_taken=0, pred_target=0 next cycle. flush overrides pred_hold and pred_vld.
- Update, upd_vld=1:
  - The counter saturates upward if upd_taken, downward if not: 11 stays 11, 00 stays 00.
  - If upd_taken, the BTB entry at the index is written: valid=1, tag from upd_pc, target=upd_target.
  - A not-taken update leaves the BTB unchanged.
- Same-cycle lookup and update to the same idx: the lookup returns the pre-update table value (read-old). The new value is visible to the next cycle's lookup.
- Aliasing: different PCs with the same idx share a counter. The BTB tag mismatch then forces not-taken.
- Stats, sampled every non-reset cycle:
  - stat_br_cnt increments on upd_vld.
  - stat_mis_cnt increments on flush.
  - Both saturate at 32'hFFFF_FFFF without wrapping.

Decomposition:
- Shared package utils_top gets:
  - the 2-bit counter typedef and encodings SNT=00, WNT=01, WT=10, ST=11;
  - the counter reset value constant;
  - the default IDX_W/TAG_W constants.
- Natural sub-module: branch_sat_cnt2, a 2-bit saturating up/down counter with sync active-low reset to WNT, instantiated once per entry via generate.
- The BTB arrays stay inline.

Test Plan:
1. Reset, then a lookup at pc=0x100 → next cycle pred_out_vld=1, pred_taken=0, pred_target=0.
2. Two updates at pc=0x100, upd_taken=1, target 0x200, then a lookup at 0x100 → pred_taken=1, pred_target=0x200. Three more taken updates, then one not-taken → still taken (counter at WT).
3. Alias: after training 0x100, look up 0x200, which has the same idx for IDX_W=6 and a different tag → pred_taken=0.
4. Lookup and not-taken update at 0x100 in the same cycle, counter at WT → that response is taken; the next lookup is not-taken.
5. Flush in the cycle after pred_vld, with pred_hold=1 → pred_out_vld=0 next cycle; stat_mis_cnt=1.
6. Assert rst_n=0 mid-stream after training → the next lookup at 0x100 is not-taken and both stat counters read 0. Force stat_br_cnt to 0xFFFFFFFF and apply upd_vld → it stays at 0xFFFFFFFF.
